// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module   : instr_fetch_unit_if
// Brief    : Fetch-unit bus bundle: control inputs, instruction-memory
//            request/response port and the decoder-facing instruction port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
);
    logic               fetch_en;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rvalid;
    logic [INSTR_W-1:0] mem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  current_instr_addr;
    logic [ADDR_W-1:0]  next_instr_addr;

    // master is the fetch unit itself
    modport master (
        input  fetch_en, redirect_valid, redirect_addr, mem_rvalid, mem_rdata, instr_ready,
        output mem_req, mem_addr, instr_valid, instr, current_instr_addr, next_instr_addr
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_addr, mem_rvalid, mem_rdata, instr_ready,
        input  mem_req, mem_addr, instr_valid, instr, current_instr_addr, next_instr_addr
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Single-outstanding instruction fetcher with a small FIFO toward
//            the decoder and branch/jump redirect flush. Define
//            FETCH_PREFETCH_BUF2_EN for a two-entry buffer (default: one).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    instr_fetch_unit_if.master  bus
);

`ifdef FETCH_PREFETCH_BUF2_EN
    localparam logic [1:0] c_DEPTH = 2'd2;
`else
    localparam logic [1:0] c_DEPTH = 2'd1;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [ADDR_W-1:0]  r_fetchAddr;
    logic [ADDR_W-1:0]  r_reqAddr;
    logic [1:0]         r_count;
    logic [INSTR_W-1:0] r_headInstr;
    logic [ADDR_W-1:0]  r_headAddr;
`ifdef FETCH_PREFETCH_BUF2_EN
    logic [INSTR_W-1:0] r_tailInstr;
    logic [ADDR_W-1:0]  r_tailAddr;
`endif

    logic       w_redirect;
    logic       w_deq;
    logic       w_enq;
    logic [1:0] w_countAfterDeq;
    logic       w_canIssue;

    // A redirect overrides both buffer ports in the cycle it is seen
    assign w_redirect      = bus.redirect_valid;
    assign w_deq           = (r_count != 2'd0) && bus.instr_ready && !w_redirect;
    assign w_enq           = (r_state == S_WAIT) && bus.mem_rvalid && !w_redirect;
    assign w_countAfterDeq = r_count - {1'b0, w_deq};
    assign w_canIssue      = bus.fetch_en && (w_countAfterDeq < c_DEPTH);

    // Whenever nothing is left outstanding after a redirect or a drained
    // response, the buffer is empty, so the redirected fetch can issue at once.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_redirect) begin
                    w_nextState = bus.fetch_en ? S_REQ : S_IDLE;
                end else if (w_canIssue) begin
                    w_nextState = S_REQ;
                end
            end
            S_REQ: begin
                w_nextState = w_redirect ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    w_nextState = (w_redirect && bus.fetch_en) ? S_REQ : S_IDLE;
                end else if (w_redirect) begin
                    w_nextState = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.mem_rvalid) begin
                    w_nextState = bus.fetch_en ? S_REQ : S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fetchAddr <= '0;
            r_reqAddr   <= '0;
            r_count     <= 2'd0;
        end else begin
            r_state <= w_nextState;
            if (w_redirect) begin
                r_fetchAddr <= bus.redirect_addr;
            end else if (r_state == S_REQ) begin
                r_fetchAddr <= r_fetchAddr + ADDR_W'(1);
            end
            if (r_state == S_REQ) begin
                r_reqAddr <= r_fetchAddr;
            end
            if (w_redirect) begin
                r_count <= 2'd0;
            end else begin
                r_count <= w_countAfterDeq + {1'b0, w_enq};
            end
        end
    end

    // Head slot is never cleared on dequeue/flush so the outputs hold last values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_headInstr <= '0;
            r_headAddr  <= '0;
`ifdef FETCH_PREFETCH_BUF2_EN
            r_tailInstr <= '0;
            r_tailAddr  <= '0;
`endif
        end else begin
`ifdef FETCH_PREFETCH_BUF2_EN
            if (w_deq && (r_count == 2'd2)) begin
                r_headInstr <= r_tailInstr;
                r_headAddr  <= r_tailAddr;
            end
            if (w_enq) begin
                if (w_countAfterDeq == 2'd0) begin
                    r_headInstr <= bus.mem_rdata;
                    r_headAddr  <= r_reqAddr;
                end else begin
                    r_tailInstr <= bus.mem_rdata;
                    r_tailAddr  <= r_reqAddr;
                end
            end
`else
            if (w_enq) begin
                r_headInstr <= bus.mem_rdata;
                r_headAddr  <= r_reqAddr;
            end
`endif
        end
    end

    assign bus.mem_req            = (r_state == S_REQ);
    assign bus.mem_addr           = r_fetchAddr;
    assign bus.instr_valid        = (r_count != 2'd0);
    assign bus.instr              = r_headInstr;
    assign bus.current_instr_addr = r_headAddr;
    assign bus.next_instr_addr    = r_headAddr + ADDR_W'(1);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed bench for instr_fetch_unit with a latency-programmable
//            memory returning addr^0xA5.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    logic clk;
    logic rst;

    instr_fetch_unit_if #(.ADDR_W(8), .INSTR_W(8)) ifc ();

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    int         nVec = 0;
    int         nErr = 0;
    int         cyc  = 0;
    int         memLat;
    int         memCnt;
    logic [7:0] memPend;
    logic       memStray;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responds memLat cycles after the cycle in which it saw mem_req
    task automatic memTick();
        ifc.mem_rvalid = 1'b0;
        if (memCnt > 0) begin
            memCnt--;
            if (memCnt == 0) begin
                ifc.mem_rvalid = 1'b1;
                ifc.mem_rdata  = memPend ^ 8'hA5;
            end
        end
        if (memStray) begin
            ifc.mem_rvalid = 1'b1;
            ifc.mem_rdata  = 8'h77;
            memStray       = 1'b0;
        end
        if (ifc.mem_req === 1'b1) begin
            memPend = ifc.mem_addr;
            memCnt  = memLat;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        memTick();
    endtask

    task automatic waitReq(input string tag, output int at);
        int n = 0;
        while (ifc.mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (ifc.mem_req !== 1'b1) chkEq({tag, "_timeout"}, 32'(ifc.mem_req), 32'd1);
        at = cyc;
    endtask

    task automatic waitValid(input string tag, output int at);
        int n = 0;
        while (ifc.instr_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (ifc.instr_valid !== 1'b1) chkEq({tag, "_timeout"}, 32'(ifc.instr_valid), 32'd1);
        at = cyc;
    endtask

    task automatic chkReset(input string p);
        chkEq({p, "_mem_req"},   32'(ifc.mem_req),            32'd0);
        chkEq({p, "_mem_addr"},  32'(ifc.mem_addr),           32'h00);
        chkEq({p, "_valid"},     32'(ifc.instr_valid),        32'd0);
        chkEq({p, "_instr"},     32'(ifc.instr),              32'h00);
        chkEq({p, "_cur_addr"},  32'(ifc.current_instr_addr), 32'h00);
        chkEq({p, "_next_addr"}, 32'(ifc.next_instr_addr),    32'h01);
    endtask

    initial begin
        int         tReq;
        int         tPrev;
        int         tVal;
        int         tRst;
        int         nReq;
        int         sawValid;
        int         n;
        logic [7:0] a;

        rst                = 1'b1;
        ifc.fetch_en       = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_addr  = 8'h00;
        ifc.mem_rvalid     = 1'b0;
        ifc.mem_rdata      = 8'h00;
        ifc.instr_ready    = 1'b0;
        memLat             = 1;
        memCnt             = 0;
        memPend            = 8'h00;
        memStray           = 1'b0;
        tPrev              = 0;

        tick();
        tick();
        chkReset("reset");

        // Sequential fetch from 0, L=1, decoder always ready
        rst             = 1'b0;
        ifc.fetch_en    = 1'b1;
        ifc.instr_ready = 1'b1;
        tRst            = cyc;
        for (int k = 0; k < 3; k++) begin
            waitReq("seq_req", tReq);
            if (k == 0) chkEq("seq_first_req_cycle", 32'(tReq - tRst), 32'd1);
            else        chkEq("seq_period", 32'(tReq - tPrev), 32'd3);
            tPrev = tReq;
            chkEq("seq_mem_addr", 32'(ifc.mem_addr), 32'(k));
            waitValid("seq_valid", tVal);
            chkEq("seq_latency", 32'(tVal - tReq), 32'd2);
            chkEq("seq_instr", 32'(ifc.instr), 32'(k ^ 8'hA5));
            chkEq("seq_cur_addr", 32'(ifc.current_instr_addr), 32'(k));
            chkEq("seq_next_addr", 32'(ifc.next_instr_addr), 32'(k + 1));
        end

        // Redirect to 0xFE from IDLE with an entry at the head; wraps past 0xFF
        ifc.redirect_valid = 1'b1;
        ifc.redirect_addr  = 8'hFE;
        tick();
        ifc.redirect_valid = 1'b0;
        chkEq("redir_flush_valid", 32'(ifc.instr_valid), 32'd0);
        chkEq("redir_req_next_cycle", 32'(ifc.mem_req), 32'd1);
        for (int k = 0; k < 3; k++) begin
            a = 8'(254 + k);
            waitReq("wrap_req", tReq);
            chkEq("wrap_mem_addr", 32'(ifc.mem_addr), 32'(a));
            waitValid("wrap_valid", tVal);
            chkEq("wrap_instr", 32'(ifc.instr), 32'(a ^ 8'hA5));
            chkEq("wrap_cur_addr", 32'(ifc.current_instr_addr), 32'(a));
            chkEq("wrap_next_addr", 32'(ifc.next_instr_addr), 32'(8'(a + 8'd1)));
        end

        // Decoder stall: head at 0x00 must stay put, requests stop when full
        ifc.instr_ready = 1'b0;
        nReq = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ifc.mem_req === 1'b1) nReq++;
        end
`ifdef FETCH_PREFETCH_BUF2_EN
        chkEq("stall_req_count", 32'(nReq), 32'd1);
`else
        chkEq("stall_req_count", 32'(nReq), 32'd0);
`endif
        chkEq("stall_valid", 32'(ifc.instr_valid), 32'd1);
        chkEq("stall_instr", 32'(ifc.instr), 32'hA5);
        chkEq("stall_cur_addr", 32'(ifc.current_instr_addr), 32'h00);
        ifc.instr_ready = 1'b1;
        tick();
        chkEq("release_req", 32'(ifc.mem_req), 32'd1);
`ifdef FETCH_PREFETCH_BUF2_EN
        chkEq("release_mem_addr", 32'(ifc.mem_addr), 32'h02);
        chkEq("release_valid", 32'(ifc.instr_valid), 32'd1);
        chkEq("release_instr", 32'(ifc.instr), 32'hA4);
        chkEq("release_cur_addr", 32'(ifc.current_instr_addr), 32'h01);
`else
        chkEq("release_mem_addr", 32'(ifc.mem_addr), 32'h01);
        chkEq("release_valid", 32'(ifc.instr_valid), 32'd0);
`endif

        // Drain, then redirect away from an outstanding L=3 request to 0x05
        ifc.fetch_en = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chkEq("drained_valid", 32'(ifc.instr_valid), 32'd0);
        memLat             = 3;
        ifc.fetch_en       = 1'b1;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_addr  = 8'h05;
        tick();
        ifc.redirect_valid = 1'b0;
        chkEq("r05_req", 32'(ifc.mem_req), 32'd1);
        chkEq("r05_mem_addr", 32'(ifc.mem_addr), 32'h05);
        tick();
        ifc.redirect_valid = 1'b1;
        ifc.redirect_addr  = 8'h40;
        tick();
        ifc.redirect_valid = 1'b0;
        sawValid = 0;
        n        = 0;
        while (ifc.mem_req !== 1'b1 && n < 20) begin
            if (ifc.instr_valid === 1'b1) sawValid++;
            tick();
            n++;
        end
        if (ifc.instr_valid === 1'b1) sawValid++;
        chkEq("drop_no_valid", 32'(sawValid), 32'd0);
        chkEq("drop_req_seen", 32'(ifc.mem_req), 32'd1);
        chkEq("drop_mem_addr", 32'(ifc.mem_addr), 32'h40);
        waitValid("drop_valid", tVal);
        chkEq("drop_instr", 32'(ifc.instr), 32'hE5);
        chkEq("drop_cur_addr", 32'(ifc.current_instr_addr), 32'h40);

        // Redirect coinciding with mem_rvalid and instr_ready
        memLat = 1;
        waitReq("coinc_req", tReq);
        tick();
        ifc.redirect_valid = 1'b1;
        ifc.redirect_addr  = 8'h80;
        ifc.instr_ready    = 1'b1;
        tick();
        ifc.redirect_valid = 1'b0;
        chkEq("coinc_flush_valid", 32'(ifc.instr_valid), 32'd0);
        waitReq("coinc_req2", tReq);
        chkEq("coinc_mem_addr", 32'(ifc.mem_addr), 32'h80);
        waitValid("coinc_valid", tVal);
        chkEq("coinc_instr", 32'(ifc.instr), 32'h25);
        chkEq("coinc_cur_addr", 32'(ifc.current_instr_addr), 32'h80);

        // Reset while waiting, then a stray response in IDLE
        memLat = 3;
        waitReq("mrst_req", tReq);
        tick();
        rst    = 1'b1;
        memCnt = 0;
        tick();
        rst          = 1'b0;
        ifc.fetch_en = 1'b0;
        memStray     = 1'b1;
        tick();
        tick();
        chkReset("mrst");
        ifc.fetch_en = 1'b1;
        waitReq("mrst_req2", tReq);
        chkEq("mrst_mem_addr", 32'(ifc.mem_addr), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

`default_nettype wire
